// File: rtl/pulse_stretcher.sv
// Stretches one-cycle event strobes into fixed-length output bursts. Each burst is
// HIGH_CYCLES high followed by GAP_CYCLES low; strobes arriving mid-burst are queued and replayed.
module pulse_stretcher #(
    parameter int unsigned HIGH_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned PEND_W      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pulse_in,
    output logic              out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int unsigned MaxPhase = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
    localparam int unsigned CntW     = (MaxPhase > 1) ? $clog2(MaxPhase) : 1;

    localparam logic [CntW-1:0]   HighLast = CntW'(HIGH_CYCLES - 1);
    localparam logic [CntW-1:0]   GapLast  = CntW'(GAP_CYCLES - 1);
    localparam logic [PEND_W-1:0] PendMax  = {PEND_W{1'b1}};

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHigh = 2'd1,
        StGap  = 2'd2
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   cnt_q;
    logic [PEND_W-1:0] pend_q;
    logic              out_q;
    logic              busy_q;
    logic              ovf_q;

    logic pend_full;
    logic gap_last;
    logic replay;

    always_comb begin
        pend_full = (pend_q == PendMax);
        gap_last  = (state_q == StGap) && (cnt_q == GapLast);
        // A strobe on the final gap edge counts toward the replay decision.
        replay    = gap_last && (pulse_in || (pend_q != '0));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pend_q  <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pulse_in) begin
                        state_q <= StHigh;
                        cnt_q   <= '0;
                        out_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                StHigh: begin
                    if (pulse_in) begin
                        if (pend_full) begin
                            ovf_q <= 1'b1;
                        end else begin
                            pend_q <= pend_q + 1'b1;
                        end
                    end
                    if (cnt_q == HighLast) begin
                        state_q <= StGap;
                        cnt_q   <= '0;
                        out_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StGap: begin
                    if (gap_last) begin
                        cnt_q <= '0;
                        if (replay) begin
                            // Increment and decrement cancel when a strobe coincides.
                            if (!pulse_in) begin
                                pend_q <= pend_q - 1'b1;
                            end
                            state_q <= StHigh;
                            out_q   <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (pulse_in) begin
                            if (pend_full) begin
                                ovf_q <= 1'b1;
                            end else begin
                                pend_q <= pend_q + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    out_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out      = out_q;
    assign busy     = busy_q;
    assign pending  = pend_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: vector table, directed corner sequences and random strobes
// checked against a timeline-based reference model.
module tb_pulse_stretcher;

    localparam int H    = 4;
    localparam int G    = 2;
    localparam int PW   = 3;
    localparam int MAXP = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pulse_in = 1'b0;
    logic          out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    int n_tests = 0;
    int n_fail  = 0;

    pulse_stretcher #(
        .HIGH_CYCLES(H),
        .GAP_CYCLES (G),
        .PEND_W     (PW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pulse_in(pulse_in),
        .out     (out),
        .busy    (busy),
        .pending (pending),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Model: a burst is described by the edge it started on; outputs follow from elapsed time.
    int m_cyc    = 0;
    bit m_active = 1'b0;
    int m_start  = 0;
    int m_pend   = 0;
    bit m_ovf    = 1'b0;

    function automatic void model_edge(input logic r, input logic p);
        int n;
        m_cyc++;
        m_ovf = 1'b0;
        if (!r) begin
            m_active = 1'b0;
            m_pend   = 0;
        end else if (!m_active) begin
            if (p) begin
                m_active = 1'b1;
                m_start  = m_cyc;
            end
        end else if (m_cyc - m_start == H + G) begin
            n = m_pend + (p ? 1 : 0);
            if (n > 0) begin
                m_start = m_cyc;
                n--;
            end else begin
                m_active = 1'b0;
            end
            m_pend = n;
        end else if (p) begin
            if (m_pend == MAXP) m_ovf = 1'b1;
            else m_pend++;
        end
    endfunction

    function automatic logic [5:0] model_outs();
        logic mo;
        mo = m_active && ((m_cyc - m_start) < H);
        return {mo, m_active, PW'(m_pend), m_ovf};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, m_cyc, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic p);
        rst_n    = r;
        pulse_in = p;
        @(posedge clk);
        #1;
        model_edge(r, p);
        check("model {out,busy,pending,overflow}", int'({out, busy, pending, overflow}),
              int'(model_outs()));
    endtask

    typedef struct {
        logic          r;
        logic          p;
        logic          eo;
        logic          eb;
        logic [PW-1:0] ep;
        logic          eov;
    } vec_t;

    vec_t tbl[20];

    initial begin
        int bursts;
        int ovf_seen;
        int hi;
        int dens;
        bit prev_out;
        bit nonzero;

        // Three back-to-back strobes after reset: three bursts at 6-edge spacing.
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0};
        tbl[17] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0};
        tbl[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};

        for (int i = 0; i < 20; i++) begin
            step(tbl[i].r, tbl[i].p);
            check($sformatf("table[%0d]", i), int'({out, busy, pending, overflow}),
                  int'({tbl[i].eo, tbl[i].eb, tbl[i].ep, tbl[i].eov}));
        end

        // Idle stability.
        step(1'b0, 1'b0);
        nonzero = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b0);
            if ({out, busy, pending, overflow} != '0) nonzero = 1'b1;
        end
        check("idle_stable", int'(nonzero), 0);

        // Saturation: strobe held for 10 edges; 8 queued, the 10th dropped.
        step(1'b0, 1'b0);
        bursts   = 0;
        ovf_seen = 0;
        prev_out = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1);
            if (out && !prev_out) bursts++;
            prev_out = out;
            if (overflow) ovf_seen++;
            if (i == 8) check("ovf_pend_full", int'(pending), MAXP);
            if (i == 8) check("ovf_not_yet", int'(overflow), 0);
            if (i == 9) check("ovf_strobe", int'(overflow), 1);
            if (i == 9) check("ovf_pend_hold", int'(pending), MAXP);
        end
        for (int i = 0; i < 200 && busy; i++) begin
            step(1'b1, 1'b0);
            if (out && !prev_out) bursts++;
            prev_out = out;
            if (overflow) ovf_seen++;
        end
        check("ovf_drained", int'(busy), 0);
        check("ovf_bursts", bursts, 9);
        check("ovf_count", ovf_seen, 1);

        // Strobe coinciding with the final gap edge of the first burst.
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("simul_pend_a", int'(pending), 1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("simul_pend_b", int'(pending), 1);
        check("simul_restart", int'(out), 1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        check("simul_gap", int'(out), 0);
        step(1'b1, 1'b0);
        check("simul_third", int'(out), 1);
        check("simul_pend_c", int'(pending), 0);
        for (int i = 0; i < 40 && busy; i++) step(1'b1, 1'b0);

        // Reset in the middle of a burst, with a strobe that must be ignored.
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        check("rst_pre_pend", int'(pending), 2);
        check("rst_pre_out", int'(out), 1);
        step(1'b0, 1'b1);
        check("rst_abort", int'({out, busy, pending, overflow}), 0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        hi = int'(out);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b0);
            hi += int'(out);
        end
        check("rst_single_burst", hi, H);
        check("rst_after_busy", int'(busy), 0);

        // Random strobes with varying density and occasional resets.
        step(1'b0, 1'b0);
        for (int blk = 0; blk < 6; blk++) begin
            dens = (blk % 3 == 0) ? 5 : ((blk % 3 == 1) ? 30 : 80);
            for (int i = 0; i < 500; i++) begin
                step(($urandom_range(0, 299) != 0), ($urandom_range(0, 99) < dens));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
